// File: rtl/clint.sv
// Core-local interruptor: msip, 64-bit mtime/mtimecmp and the rtc tick divider.
// Single-cycle bus slave with registered read data and ready.
module clint #(
    parameter logic [31:0] clint_base_addr = 32'h0200_0000,
    parameter int unsigned clk_divider_rtc = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        clint_valid,
    input  logic [31:0] clint_addr,
    input  logic [31:0] clint_wdata,
    input  logic [3:0]  clint_wstrb,
    output logic [31:0] clint_rdata,
    output logic        clint_ready,
    output logic        clint_msip,
    output logic        clint_mtip,
    output logic [63:0] clint_mtime
);

    localparam logic [31:0] OFF_MSIP   = 32'h0000_0000;
    localparam logic [31:0] OFF_CMP_LO = 32'h0000_4000;
    localparam logic [31:0] OFF_CMP_HI = 32'h0000_4004;
    localparam logic [31:0] OFF_TIM_LO = 32'h0000_BFF8;
    localparam logic [31:0] OFF_TIM_HI = 32'h0000_BFFC;
    localparam logic [31:0] DIV_LAST   = 32'(clk_divider_rtc);

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  strb);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                r[8*i +: 8] = new_v[8*i +: 8];
            end else begin
                r[8*i +: 8] = old_v[8*i +: 8];
            end
        end
        return r;
    endfunction

    logic        msip_q, msip_d;
    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic [31:0] div_q, div_d;
    logic        rtc_q, rtc_d;
    logic        mtip_q, mtip_d;
    logic        ready_q, ready_d;
    logic [31:0] rdata_q, rdata_d;

    logic [31:0] offset_s;
    logic [31:0] word_s;
    logic        wr_s;
    logic        wrap_s;
    logic        tick_s;

    // Address decode, tick generation and next-state for all registers.
    always_comb begin
        offset_s   = clint_addr - clint_base_addr;
        word_s     = {offset_s[31:2], 2'b00};
        wr_s       = clint_valid && (clint_wstrb != 4'b0000);
        wrap_s     = (div_q == DIV_LAST);
        // The tick marks the wrap that completes a full rtc period (rtc high -> low).
        tick_s     = wrap_s && rtc_q;
        div_d      = wrap_s ? 32'd0 : div_q + 32'd1;
        rtc_d      = rtc_q ^ wrap_s;
        msip_d     = msip_q;
        mtimecmp_d = mtimecmp_q;
        mtime_d    = tick_s ? mtime_q + 64'd1 : mtime_q;
        mtip_d     = (mtime_q >= mtimecmp_q);
        ready_d    = clint_valid;
        rdata_d    = 32'd0;

        if (clint_valid) begin
            case (word_s)
                OFF_MSIP:   rdata_d = {31'd0, msip_q};
                OFF_CMP_LO: rdata_d = mtimecmp_q[31:0];
                OFF_CMP_HI: rdata_d = mtimecmp_q[63:32];
                OFF_TIM_LO: rdata_d = mtime_q[31:0];
                OFF_TIM_HI: rdata_d = mtime_q[63:32];
                default:    rdata_d = 32'd0;
            endcase
        end else begin
            rdata_d = 32'd0;
        end

        // A bus write to an mtime word overrides the tick increment for that cycle.
        if (wr_s) begin
            case (word_s)
                OFF_MSIP: begin
                    if (clint_wstrb[0]) begin
                        msip_d = clint_wdata[0];
                    end else begin
                        msip_d = msip_q;
                    end
                end
                OFF_CMP_LO: mtimecmp_d = {mtimecmp_q[63:32],
                                          merge_bytes(mtimecmp_q[31:0], clint_wdata, clint_wstrb)};
                OFF_CMP_HI: mtimecmp_d = {merge_bytes(mtimecmp_q[63:32], clint_wdata, clint_wstrb),
                                          mtimecmp_q[31:0]};
                OFF_TIM_LO: mtime_d    = {mtime_q[63:32],
                                          merge_bytes(mtime_q[31:0], clint_wdata, clint_wstrb)};
                OFF_TIM_HI: mtime_d    = {merge_bytes(mtime_q[63:32], clint_wdata, clint_wstrb),
                                          mtime_q[31:0]};
                default:    msip_d     = msip_q;
            endcase
        end else begin
            msip_d = msip_q;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            msip_q     <= 1'b0;
            mtime_q    <= 64'd0;
            mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
            div_q      <= 32'd0;
            rtc_q      <= 1'b0;
            mtip_q     <= 1'b0;
            ready_q    <= 1'b0;
            rdata_q    <= 32'd0;
        end else begin
            msip_q     <= msip_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            div_q      <= div_d;
            rtc_q      <= rtc_d;
            mtip_q     <= mtip_d;
            ready_q    <= ready_d;
            rdata_q    <= rdata_d;
        end
    end

    assign clint_rdata = rdata_q;
    assign clint_ready = ready_q;
    assign clint_msip  = msip_q;
    assign clint_mtip  = mtip_q;
    assign clint_mtime = mtime_q;

endmodule

// File: tb/tb_clint.sv
// Directed bench for clint: vector table for register accesses plus
// hand-written sequences for tick timing, interrupts, collision and reset.
module tb_clint;

    localparam logic [31:0] BASE = 32'h0200_0000;

    logic        clock;
    logic        reset;
    logic        clint_valid;
    logic [31:0] clint_addr;
    logic [31:0] clint_wdata;
    logic [3:0]  clint_wstrb;
    logic [31:0] clint_rdata;
    logic        clint_ready;
    logic        clint_msip;
    logic        clint_mtip;
    logic [63:0] clint_mtime;

    int n_pass  = 0;
    int n_total = 0;
    int cyc;

    clint dut (
        .clock       (clock),
        .reset       (reset),
        .clint_valid (clint_valid),
        .clint_addr  (clint_addr),
        .clint_wdata (clint_wdata),
        .clint_wstrb (clint_wstrb),
        .clint_rdata (clint_rdata),
        .clint_ready (clint_ready),
        .clint_msip  (clint_msip),
        .clint_mtip  (clint_mtip),
        .clint_mtime (clint_mtime)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Rising edges since the last reset release.
    always @(posedge clock or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic        exp_msip;
    } vec_t;

    vec_t vecs [15];

    function automatic vec_t mkv(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                                 input logic c, input logic [31:0] e, input logic m);
        vec_t v;
        v.addr = a; v.wdata = d; v.strb = s; v.chk_rd = c; v.exp_rd = e; v.exp_msip = m;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic access(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        @(negedge clock);
        clint_valid = 1'b1;
        clint_addr  = a;
        clint_wdata = d;
        clint_wstrb = s;
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        @(negedge clock);
        clint_valid = 1'b0;
        clint_wstrb = 4'b0000;
    endtask

    initial begin
        bit found;
        clint_valid = 1'b0;
        clint_addr  = 32'd0;
        clint_wdata = 32'd0;
        clint_wstrb = 4'b0000;
        reset       = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;

        chk("rst_ready", {63'd0, clint_ready}, 64'd0);
        chk("rst_rdata", {32'd0, clint_rdata}, 64'd0);
        chk("rst_mtip",  {63'd0, clint_mtip},  64'd0);
        chk("rst_msip",  {63'd0, clint_msip},  64'd0);
        chk("rst_mtime", clint_mtime, 64'd0);

        // Tick rate: mtime must equal floor(edges/10) at every edge.
        for (int i = 1; i <= 100; i++) begin
            @(posedge clock);
            #1;
            chk("tick_rate", clint_mtime, 64'(cyc / 10));
        end
        chk("mtime_after_100", clint_mtime, 64'd10);

        // Dirty some state, then reset in the middle of an access.
        access(BASE + 32'h0000, 32'h0000_0001, 4'b1111);
        access(BASE + 32'h4004, 32'h0000_0000, 4'b1111);
        access(BASE + 32'h4000, 32'h0000_0000, 4'b1111);
        access(BASE + 32'hBFF8, 32'h0000_0000, 4'b0000);
        chk("pre_rst_ready", {63'd0, clint_ready}, 64'd1);
        chk("pre_rst_msip",  {63'd0, clint_msip},  64'd1);
        chk("pre_rst_mtip",  {63'd0, clint_mtip},  64'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_ready", {63'd0, clint_ready}, 64'd0);
        chk("midrst_rdata", {32'd0, clint_rdata}, 64'd0);
        chk("midrst_msip",  {63'd0, clint_msip},  64'd0);
        chk("midrst_mtip",  {63'd0, clint_mtip},  64'd0);
        chk("midrst_mtime", clint_mtime, 64'd0);
        clint_valid = 1'b0;
        @(negedge clock);
        reset = 1'b1;

        vecs[0]  = mkv(BASE + 32'h4000, 32'h0,         4'b0000, 1'b1, 32'hFFFF_FFFF, 1'b0);
        vecs[1]  = mkv(BASE + 32'h4004, 32'h0,         4'b0000, 1'b1, 32'hFFFF_FFFF, 1'b0);
        vecs[2]  = mkv(BASE + 32'hBFF8, 32'h0,         4'b0000, 1'b1, 32'h0000_0000, 1'b0);
        vecs[3]  = mkv(BASE + 32'h0000, 32'h0,         4'b0000, 1'b1, 32'h0000_0000, 1'b0);
        vecs[4]  = mkv(BASE + 32'h0000, 32'hFFFF_FFFF, 4'b1111, 1'b0, 32'h0,         1'b1);
        vecs[5]  = mkv(BASE + 32'h0000, 32'h0,         4'b0000, 1'b1, 32'h0000_0001, 1'b1);
        vecs[6]  = mkv(BASE + 32'h0000, 32'hFFFF_FFFE, 4'b0001, 1'b0, 32'h0,         1'b0);
        vecs[7]  = mkv(BASE + 32'h0000, 32'h0,         4'b0000, 1'b1, 32'h0000_0000, 1'b0);
        vecs[8]  = mkv(BASE + 32'h0000, 32'hFFFF_FFFF, 4'b1110, 1'b0, 32'h0,         1'b0);
        vecs[9]  = mkv(BASE + 32'h0000, 32'h0,         4'b0000, 1'b1, 32'h0000_0000, 1'b0);
        vecs[10] = mkv(32'h2000_0010,   32'h0,         4'b0000, 1'b1, 32'h0000_0000, 1'b0);
        vecs[11] = mkv(BASE + 32'h4000, 32'hDEAD_BEEF, 4'b0101, 1'b0, 32'h0,         1'b0);
        vecs[12] = mkv(BASE + 32'h4000, 32'h0,         4'b0000, 1'b1, 32'hFFAD_FFEF, 1'b0);
        vecs[13] = mkv(BASE + 32'h4000, 32'hFFFF_FFFF, 4'b1111, 1'b0, 32'h0,         1'b0);
        vecs[14] = mkv(BASE + 32'h4002, 32'h0,         4'b0000, 1'b1, 32'hFFFF_FFFF, 1'b0);

        for (int i = 0; i < 15; i++) begin
            access(vecs[i].addr, vecs[i].wdata, vecs[i].strb);
            chk($sformatf("vec%0d_ready", i), {63'd0, clint_ready}, 64'd1);
            chk($sformatf("vec%0d_msip", i),  {63'd0, clint_msip},  {63'd0, vecs[i].exp_msip});
            chk($sformatf("vec%0d_mtip", i),  {63'd0, clint_mtip},  64'd0);
            if (vecs[i].chk_rd) chk($sformatf("vec%0d_rdata", i), {32'd0, clint_rdata}, {32'd0, vecs[i].exp_rd});
        end
        idle();
        @(posedge clock);
        #1;
        chk("idle_ready", {63'd0, clint_ready}, 64'd0);
        chk("idle_rdata", {32'd0, clint_rdata}, 64'd0);

        // Timer interrupt: mtimecmp = 5.
        access(BASE + 32'h4004, 32'h0000_0000, 4'b1111);
        access(BASE + 32'h4000, 32'h0000_0005, 4'b1111);
        idle();
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(posedge clock);
            #1;
            if (clint_mtime == 64'd5) found = 1'b1;
        end
        chk("mtime_reach5", {63'd0, found}, 64'd1);
        chk("mtip_same_edge", {63'd0, clint_mtip}, 64'd0);
        @(posedge clock);
        #1;
        chk("mtip_rise", {63'd0, clint_mtip}, 64'd1);
        access(BASE + 32'h4000, 32'h0000_0064, 4'b1111);
        chk("mtip_hold", {63'd0, clint_mtip}, 64'd1);
        idle();
        @(posedge clock);
        #1;
        chk("mtip_clear", {63'd0, clint_mtip}, 64'd0);

        // Write/tick collision on the low mtime word.
        while (cyc % 10 != 1) begin
            @(posedge clock);
            #1;
        end
        access(BASE + 32'hBFF8, 32'h1234_0007, 4'b1111);
        access(BASE + 32'hBFFC, 32'h0000_0000, 4'b1111);
        idle();
        chk("coll_setup", clint_mtime, 64'h0000_0000_1234_0007);
        while (cyc % 10 != 9) begin
            @(posedge clock);
            #1;
        end
        access(BASE + 32'hBFF8, 32'h0000_ABCD, 4'b0011);
        chk("coll_edge_is_tick", 64'(cyc % 10), 64'd0);
        chk("coll_mtime", clint_mtime, 64'h0000_0000_1234_ABCD);
        idle();
        repeat (10) @(posedge clock);
        #1;
        chk("coll_next_tick", clint_mtime, 64'h0000_0000_1234_ABCE);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
